// File: rtl/uart_rx.sv
// UART serial receiver: 2-flop synchronizer, mid-bit sampling of start/8 data/optional
// parity/stop, one-cycle data_valid pulse with held data and parity/framing flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  input  logic       parity_en,
  input  logic       even_parity,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift_reg;
  logic          par_bit;
  logic          pen_l;
  logic          even_l;
  logic          brk;

  function automatic logic parity_bit(input logic [7:0] d, input logic even);
    return even ? ^d : ~^d;
  endfunction

  // rx_serial is asynchronous to clk; both flops idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      pen_l      <= 1'b0;
      even_l     <= 1'b0;
      brk        <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          brk <= 1'b0;
          if (!rx_s) begin
            state  <= START;
            busy   <= 1'b1;
            pen_l  <= parity_en;
            even_l <= even_parity;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (idx == 3'd7) state <= pen_l ? PARITY : STOP;
            else             idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // After a low stop bit, wait out the line break instead of re-framing it
          if (brk) begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
              brk   <= 1'b0;
            end
          end else if (cnt == CNT_LAST) begin
            cnt        <= '0;
            data_valid <= 1'b1;
            data_out   <= shift_reg;
            parity_err <= pen_l && (par_bit != parity_bit(shift_reg, even_l));
            frame_err  <= !rx_s;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              brk <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames bit by bit and checks the
// captured byte, valid pulse count and flags against hand-computed values.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_serial;
  logic       parity_en;
  logic       even_parity;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int vld_total = 0;
  logic [7:0] cap [0:63];
  logic busy_mid;
  logic busy_seen;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial), .parity_en(parity_en),
    .even_parity(even_parity), .data_out(data_out), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin
      cap[vld_total[5:0]] = data_out;
      vld_total = vld_total + 1;
    end
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_serial = b;
    repeat (CPB) @(negedge clk);
  endtask

  // toggle_pen flips parity_en during data bit 4 to prove it is latched at frame start
  task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par,
                            input logic stop, input logic toggle_pen);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) busy_mid = busy;
      if (i == 4 && toggle_pen) parity_en = ~parity_en;
      drive_bit(d[i]);
    end
    if (with_par) drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    rx_serial = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  int base;

  initial begin
    rst_n = 1'b0;
    rx_serial = 1'b1;
    parity_en = 1'b0;
    even_parity = 1'b0;
    busy_mid = 1'b0;
    busy_seen = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle_bits(2);

    // 0xA5, no parity, good stop
    base = vld_total;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    check("t1_busy_mid", 32'(busy_mid), 32'h1);
    check("t1_vld_count", 32'(vld_total - base), 32'd1);
    check("t1_data", 32'(data_out), 32'hA5);
    check("t1_perr", 32'(parity_err), 32'h0);
    check("t1_ferr", 32'(frame_err), 32'h0);
    check("t1_busy_after", 32'(busy), 32'h0);

    // even parity on 0x3C (four ones): parity bit 0 is correct, 1 is wrong
    parity_en = 1'b1;
    even_parity = 1'b1;
    base = vld_total;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    check("t2_good_vld", 32'(vld_total - base), 32'd1);
    check("t2_good_data", 32'(data_out), 32'h3C);
    check("t2_good_perr", 32'(parity_err), 32'h0);
    base = vld_total;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_bits(2);
    check("t2_bad_vld", 32'(vld_total - base), 32'd1);
    check("t2_bad_data", 32'(data_out), 32'h3C);
    check("t2_bad_perr", 32'(parity_err), 32'h1);
    check("t2_bad_ferr", 32'(frame_err), 32'h0);

    // odd parity on 0x01 (one one): parity bit 0 is correct
    even_parity = 1'b0;
    base = vld_total;
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    check("t3_vld", 32'(vld_total - base), 32'd1);
    check("t3_data", 32'(data_out), 32'h01);
    check("t3_perr", 32'(parity_err), 32'h0);
    // parity_en dropped mid-frame: frame still decoded with parity
    base = vld_total;
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    check("t3_tog_vld", 32'(vld_total - base), 32'd1);
    check("t3_tog_data", 32'(data_out), 32'h01);
    check("t3_tog_perr", 32'(parity_err), 32'h0);
    check("t3_tog_ferr", 32'(frame_err), 32'h0);

    // 0x55 with low stop, line held low 20 bit times
    parity_en = 1'b0;
    base = vld_total;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    rx_serial = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    check("t4_brk_busy", 32'(busy), 32'h1);
    idle_bits(2);
    check("t4_brk_vld", 32'(vld_total - base), 32'd1);
    check("t4_brk_data", 32'(data_out), 32'h55);
    check("t4_brk_ferr", 32'(frame_err), 32'h1);
    check("t4_brk_busy_after", 32'(busy), 32'h0);
    base = vld_total;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    check("t4_good_vld", 32'(vld_total - base), 32'd1);
    check("t4_good_ferr", 32'(frame_err), 32'h0);

    // 2-cycle low glitch in IDLE
    base = vld_total;
    busy_seen = 1'b0;
    rx_serial = 1'b0;
    repeat (2) @(negedge clk);
    idle_bits(3);
    check("t5_busy_seen", 32'(busy_seen), 32'h1);
    check("t5_vld", 32'(vld_total - base), 32'd0);
    check("t5_busy_after", 32'(busy), 32'h0);
    check("t5_data_held", 32'(data_out), 32'h55);
    check("t5_ferr_held", 32'(frame_err), 32'h0);

    // asynchronous reset in the middle of the data bits
    base = vld_total;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx_serial = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_data", 32'(data_out), 32'h00);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_vld", 32'(data_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_bits(12);
    check("t6_no_vld", 32'(vld_total - base), 32'd0);
    // back-to-back 0xFF then 0x00
    base = vld_total;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    check("t6_b2b_vld", 32'(vld_total - base), 32'd2);
    check("t6_b2b_first", 32'(cap[base[5:0]]), 32'hFF);
    check("t6_b2b_second", 32'(cap[6'(base + 1)]), 32'h00);
    check("t6_b2b_ferr", 32'(frame_err), 32'h0);
    check("t6_b2b_perr", 32'(parity_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
